ex_alu_stage: RTL and testbench
===============================

# ex_alu_stage

Registered execute stage of the RISC-V pipeline. It takes decoded ALU operations from the ID stage, evaluates them on 64-bit operands, and hands results to the MEM stage. Shifts use the team's shift units; add/sub/compare use the existing adder and set-less-than logic. Decoupled valid/ready handshakes on both sides, plus a two-entry output buffer (output register + skid register), let the stage absorb one cycle of downstream back-pressure without combinational ready paths.

## Interface
- XLEN, 64, operand/result width
- RD_W, 5, destination register index width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous kill of all held and incoming ops (branch redirect)
- in_valid  input  1  ID presents an op
- in_ready  output  1  stage can accept an op this cycle
- in_op  input  4  ALU opcode
- in_a  input  XLEN  operand A (rs1)
- in_b  input  XLEN  operand B (rs2 or immediate)
- in_rd  input  RD_W  destination register
- in_wen  input  1  op writes rd
- out_valid  output  1  result held for MEM
- out_ready  input  1  MEM accepts result
- out_result  output  XLEN  ALU result
- out_rd  output  RD_W  destination register
- out_wen  output  1  register write enable
- fwd_valid  output  1  forwarding entry valid (equals out_valid && out_wen)
- fwd_rd  output  RD_W  forwarding register index (= out_rd)
- fwd_data  output  XLEN  forwarding value (= out_result)

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 SLL a<<b[5:0]; 6 SRL logical a>>b[5:0]; 7 SRA arithmetic a>>>b[5:0]; 8 SLT signed a<b -> 1/0; 9 SLTU unsigned a<b -> 1/0; 10 PASSB result=b (LUI path); 11-15 illegal -> result 0, wen 0.
- All arithmetic modulo 2^XLEN; overflow ignored. Shift amount uses b[5:0] only, upper bits ignored; shift by 0 returns a.
- in_rd == 0 forces out_wen = 0 (x0 never written); result still computed.
- Storage: output register (OR) drives out_*; skid register (SK) holds one overflow entry.
- Accept = in_valid && in_ready. Result computed in accept cycle, written to OR if OR empty or OR drains this cycle, otherwise to SK.
- When OR drains (out_valid && out_ready) and SK valid, SK moves to OR same edge; SK becomes empty.
- in_ready = !SK_valid && !rst; registered-state only, no combinational path from out_ready.
- Order preserved: results leave in acceptance order; SK never bypassed by a new input.
- Flush: at the edge, OR and SK valids cleared; op accepted in flush cycle discarded; out_ready ignored that cycle. Data fields need not clear.
- Simultaneous flush and rst: rst dominates, same effect.

## Timing
- Reset (rst high at edge): out_valid=0, out_result=0, out_rd=0, out_wen=0, fwd_valid=0, SK empty; in_ready=0 while rst high, 1 first cycle after.
- Latency: op accepted at edge N appears on out_* during cycle N+1 (1 cycle) when OR free.
- Throughput: 1 op/cycle with out_ready held high.
- Back-pressure: out_ready low with OR full -> next accepted op goes to SK, in_ready drops the following cycle; resumes one cycle after OR drains.
- Output stability: while out_valid && !out_ready, out_* unchanged.
- fwd_* are functions of OR only, valid from cycle N+1.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_result=0, in_ready=0; first cycle after -> in_ready=1, nothing emitted.
- ALU sweep, out_ready=1: ADD 0xFFFF_FFFF_FFFF_FFFF+1 -> 0; SUB 0-1 -> all ones; SLL 1 by b=63 -> 0x8000_0000_0000_0000; SLL 1 by b=0x40 -> 1; SRA 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000; SRL same -> 0x0800_0000_0000_0000; SLT -1<1 -> 1; SLTU -1<1 -> 0; each one cycle after accept.
- x0 and illegal: ADD rd=0 wen=1 -> out_wen=0, fwd_valid=0; op=13 -> result 0, wen 0.
- Back-pressure: stream ops A,B,C,D each cycle, out_ready low 3 cycles -> A in OR, B in SK, in_ready low; C,D held by ID; on release results A,B,C,D in order, no loss/duplicate.
- Flush: OR and SK full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed op never appears.
- Random: 10k random ops, random out_ready/in_valid/rare flush vs reference model -> exact result/rd/wen sequence match.

Source files
------------

// File: rtl/ex_alu_stage.sv
// Execute stage: evaluates one decoded ALU op per cycle and hands the result to MEM
// through an output register backed by a one-entry skid register.
module ex_alu_stage #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen,
    output logic            fwd_valid,
    output logic [RD_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_PASSB = 4'd10
    } aluOp_e;

    logic [XLEN-1:0] w_result;
    logic            w_legal;
    logic            w_wen;
    logic [5:0]      w_shamt;
    logic            w_accept;
    logic            w_orDrain;

    logic            r_orValid;
    logic [XLEN-1:0] r_orResult;
    logic [RD_W-1:0] r_orRd;
    logic            r_orWen;
    logic            r_skValid;
    logic [XLEN-1:0] r_skResult;
    logic [RD_W-1:0] r_skRd;
    logic            r_skWen;

    assign w_shamt = in_b[5:0];

    always_comb begin
        w_result = '0;
        w_legal  = 1'b1;
        case (in_op)
            OP_ADD:   w_result = in_a + in_b;
            OP_SUB:   w_result = in_a - in_b;
            OP_AND:   w_result = in_a & in_b;
            OP_OR:    w_result = in_a | in_b;
            OP_XOR:   w_result = in_a ^ in_b;
            OP_SLL:   w_result = in_a << w_shamt;
            OP_SRL:   w_result = in_a >> w_shamt;
            OP_SRA:   w_result = $unsigned($signed(in_a) >>> w_shamt);
            OP_SLT:   w_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU:  w_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            OP_PASSB: w_result = in_b;
            default: begin
                w_result = '0;
                w_legal  = 1'b0;
            end
        endcase
    end

    // x0 is hardwired zero, so a write to it is dropped here rather than in the regfile
    assign w_wen     = in_wen && w_legal && (in_rd != '0);
    assign in_ready  = !r_skValid && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_orDrain = r_orValid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_orValid  <= 1'b0;
            r_orResult <= '0;
            r_orRd     <= '0;
            r_orWen    <= 1'b0;
            r_skValid  <= 1'b0;
            r_skResult <= '0;
            r_skRd     <= '0;
            r_skWen    <= 1'b0;
        end else if (flush) begin
            r_orValid <= 1'b0;
            r_skValid <= 1'b0;
        end else if (w_orDrain || !r_orValid) begin
            // OR is free at this edge: the skid entry is older than any new op, so it goes first
            if (r_skValid) begin
                r_orValid  <= 1'b1;
                r_orResult <= r_skResult;
                r_orRd     <= r_skRd;
                r_orWen    <= r_skWen;
                r_skValid  <= 1'b0;
            end else if (w_accept) begin
                r_orValid  <= 1'b1;
                r_orResult <= w_result;
                r_orRd     <= in_rd;
                r_orWen    <= w_wen;
            end else begin
                r_orValid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skValid  <= 1'b1;
            r_skResult <= w_result;
            r_skRd     <= in_rd;
            r_skWen    <= w_wen;
        end
    end

    assign out_valid  = r_orValid;
    assign out_result = r_orResult;
    assign out_rd     = r_orRd;
    assign out_wen    = r_orWen;
    assign fwd_valid  = r_orValid && r_orWen;
    assign fwd_rd     = r_orRd;
    assign fwd_data   = r_orResult;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed scenarios plus a randomised run
// scored against a behavioural ALU model through an in-order expectation queue.
module tb_ex_alu_stage;

    localparam int XLEN = 64;
    localparam int RD_W = 5;

    typedef struct {
        logic [XLEN-1:0] result;
        logic [RD_W-1:0] rd;
        logic            wen;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [RD_W-1:0] in_rd;
    logic            in_wen;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_wen;
    logic            fwd_valid;
    logic [RD_W-1:0] fwd_rd;
    logic [XLEN-1:0] fwd_data;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    exp_t expItem;

    logic            obsAcc;
    logic            obsDrain;
    logic            obsStall;
    logic [XLEN-1:0] obsResult;
    logic [RD_W-1:0] obsRd;
    logic            obsWen;
    logic            obsFwdValid;
    logic [RD_W-1:0] obsFwdRd;
    logic [XLEN-1:0] obsFwdData;

    ex_alu_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wen(out_wen),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] refAlu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        int sh;
        sh = int'(b[5:0]);
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a + (~b) + 64'd1;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7: begin
                r = a >> sh;
                if (a[XLEN-1] && sh != 0) r = r | ~({XLEN{1'b1}} >> sh);
            end
            4'd8:  r = ((a[63] & ~b[63]) | (~(a[63] ^ b[63]) & (a < b))) ? 64'd1 : 64'd0;
            4'd9:  r = (a < b) ? 64'd1 : 64'd0;
            4'd10: r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Drives one cycle, records what the DUT shows before the edge and books accepted ops
    task automatic step(input logic v, input logic [3:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [RD_W-1:0] rd, input logic wen,
                        input logic rdy, input logic fl);
        exp_t e;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_rd     = rd;
        in_wen    = wen;
        out_ready = rdy;
        flush     = fl;
        #1;
        obsAcc      = in_valid && in_ready && !flush;
        obsDrain    = out_valid && out_ready && !flush;
        obsStall    = out_valid && !out_ready && !flush;
        obsResult   = out_result;
        obsRd       = out_rd;
        obsWen      = out_wen;
        obsFwdValid = fwd_valid;
        obsFwdRd    = fwd_rd;
        obsFwdData  = fwd_data;
        if (fl) begin
            sb.delete();
        end else if (obsAcc) begin
            e.result = refAlu(op, a, b);
            e.rd     = rd;
            e.wen    = wen && (rd != '0) && (op <= 4'd10);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_op = 4'd0; in_a = 64'd5; in_b = 64'd7; in_rd = 5'd1; in_wen = 1'b1;
        out_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || out_result !== '0 || in_ready !== 1'b0 || fwd_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d: out_valid=%b out_result=%h in_ready=%b fwd_valid=%b, required 0/0/0/0",
                         i, out_valid, out_result, in_ready, fwd_valid);
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
        step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_wen !== 1'b0 || out_rd !== '0) begin
            errors++;
            $display("[TB] FAIL reset_nothing_emitted: out_valid=%b out_wen=%b out_rd=%0d, required 0/0/0",
                     out_valid, out_wen, out_rd);
        end
    endtask

    task automatic test_alu_sweep();
        logic [3:0]      ops [12];
        logic [XLEN-1:0] as  [12];
        logic [XLEN-1:0] bs  [12];
        logic [XLEN-1:0] exps[12];
        ops[0]  = 4'd0;  as[0]  = 64'hFFFF_FFFF_FFFF_FFFF; bs[0]  = 64'd1;  exps[0]  = 64'd0;
        ops[1]  = 4'd1;  as[1]  = 64'd0;                   bs[1]  = 64'd1;  exps[1]  = 64'hFFFF_FFFF_FFFF_FFFF;
        ops[2]  = 4'd5;  as[2]  = 64'd1;                   bs[2]  = 64'd63; exps[2]  = 64'h8000_0000_0000_0000;
        ops[3]  = 4'd5;  as[3]  = 64'd1;                   bs[3]  = 64'h40; exps[3]  = 64'd1;
        ops[4]  = 4'd7;  as[4]  = 64'h8000_0000_0000_0000; bs[4]  = 64'd4;  exps[4]  = 64'hF800_0000_0000_0000;
        ops[5]  = 4'd6;  as[5]  = 64'h8000_0000_0000_0000; bs[5]  = 64'd4;  exps[5]  = 64'h0800_0000_0000_0000;
        ops[6]  = 4'd8;  as[6]  = 64'hFFFF_FFFF_FFFF_FFFF; bs[6]  = 64'd1;  exps[6]  = 64'd1;
        ops[7]  = 4'd9;  as[7]  = 64'hFFFF_FFFF_FFFF_FFFF; bs[7]  = 64'd1;  exps[7]  = 64'd0;
        ops[8]  = 4'd2;  as[8]  = 64'hF0F0_0000_FFFF_1234; bs[8]  = 64'h0FF0_FFFF_00FF_FF00; exps[8] = 64'h00F0_0000_00FF_1200;
        ops[9]  = 4'd3;  as[9]  = 64'hF000_0000_0000_000F; bs[9]  = 64'h0F00_0000_0000_00F0; exps[9] = 64'hFF00_0000_0000_00FF;
        ops[10] = 4'd4;  as[10] = 64'hAAAA_AAAA_AAAA_AAAA; bs[10] = 64'hFFFF_0000_FFFF_0000; exps[10] = 64'h5555_AAAA_5555_AAAA;
        ops[11] = 4'd10; as[11] = 64'h1234;                bs[11] = 64'hDEAD_BEEF_0000_1000; exps[11] = 64'hDEAD_BEEF_0000_1000;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, ops[i], as[i], bs[i], 5'd3, 1'b1, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_result !== exps[i] || out_wen !== 1'b1 || out_rd !== 5'd3) begin
                errors++;
                $display("[TB] FAIL alu_op%0d idx%0d: valid=%b result=%h wen=%b rd=%0d, required 1 %h 1 3",
                         ops[i], i, out_valid, out_result, out_wen, out_rd, exps[i]);
            end
        end
        step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        sb.delete();
    endtask

    task automatic test_x0_illegal();
        step(1'b1, 4'd0, 64'd40, 64'd2, 5'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 64'd42 || out_wen !== 1'b0 || fwd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL x0_write: valid=%b result=%h wen=%b fwd_valid=%b, required 1 2a 0 0",
                     out_valid, out_result, out_wen, fwd_valid);
        end
        step(1'b1, 4'd13, 64'd40, 64'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 64'd0 || out_wen !== 1'b0 || fwd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_op: valid=%b result=%h wen=%b fwd_valid=%b, required 1 0 0 0",
                     out_valid, out_result, out_wen, fwd_valid);
        end
        step(1'b1, 4'd0, 64'd1, 64'd2, 5'd9, 1'b1, 1'b1, 1'b0);
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd9 || fwd_data !== 64'd3) begin
            errors++;
            $display("[TB] FAIL fwd_path: fwd_valid=%b fwd_rd=%0d fwd_data=%h, required 1 9 3",
                     fwd_valid, fwd_rd, fwd_data);
        end
        step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        sb.delete();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] vals[4];
        int idx;
        int drains;
        vals[0] = 64'h1111; vals[1] = 64'h2222; vals[2] = 64'h3333; vals[3] = 64'h4444;
        idx = 0;
        drains = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (idx < 4)
                step(1'b1, 4'd10, 64'd0, vals[idx], 5'(idx + 1), 1'b1, (cyc >= 3), 1'b0);
            else
                step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
            if (obsAcc) idx++;
            if (obsDrain) begin
                drains++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL bp_extra_output: result=%h emitted with nothing outstanding", obsResult);
                end else begin
                    expItem = sb.pop_front();
                    if (obsResult !== expItem.result || obsRd !== expItem.rd || obsWen !== expItem.wen) begin
                        errors++;
                        $display("[TB] FAIL bp_order: got %h rd%0d wen%b, required %h rd%0d wen%b",
                                 obsResult, obsRd, obsWen, expItem.result, expItem.rd, expItem.wen);
                    end
                end
            end
            if (cyc == 1) begin
                checks++;
                if (in_ready !== 1'b0 || out_result !== vals[0]) begin
                    errors++;
                    $display("[TB] FAIL bp_stall: in_ready=%b out_result=%h, required 0 %h",
                             in_ready, out_result, vals[0]);
                end
            end
            if (idx == 4 && sb.size() == 0 && drains > 0) break;
        end
        checks++;
        if (drains != 4 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_count: drained=%0d outstanding=%0d, required 4 0", drains, sb.size());
        end
    endtask

    task automatic test_flush();
        step(1'b1, 4'd10, '0, 64'hAAAA, 5'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd10, '0, 64'hBBBB, 5'd2, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_fill: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
        end
        step(1'b1, 4'd10, '0, 64'hCCCC, 5'd3, 1'b1, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_clear: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        step(1'b1, 4'd10, '0, 64'hDDDD, 5'd4, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_leak: out_valid=%b result=%h after flush, required 0",
                         out_valid, out_result);
            end
        end
    endtask

    task automatic test_random();
        int accepted;
        int cyc;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0] op;
        accepted = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 40000) begin
            op = 4'($urandom_range(0, 15));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = {XLEN{a[0]}};
            if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 70));
            step(($urandom_range(0, 3) != 0), op, a, b, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
            cyc++;
            if (obsAcc) accepted++;
            if (obsStall) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== obsResult || out_rd !== obsRd || out_wen !== obsWen) begin
                    errors++;
                    $display("[TB] FAIL rand_stability cyc%0d: %b %h rd%0d wen%b, required 1 %h rd%0d wen%b",
                             cyc, out_valid, out_result, out_rd, out_wen, obsResult, obsRd, obsWen);
                end
            end
            if (obsDrain) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_extra_output cyc%0d: result=%h with nothing outstanding", cyc, obsResult);
                end else begin
                    expItem = sb.pop_front();
                    if (obsResult !== expItem.result || obsRd !== expItem.rd || obsWen !== expItem.wen ||
                        obsFwdValid !== expItem.wen || obsFwdRd !== expItem.rd || obsFwdData !== expItem.result) begin
                        errors++;
                        $display("[TB] FAIL rand_result cyc%0d: got %h rd%0d wen%b fwd%b, required %h rd%0d wen%b",
                                 cyc, obsResult, obsRd, obsWen, obsFwdValid, expItem.result, expItem.rd, expItem.wen);
                    end
                end
            end
        end
        checks++;
        if (accepted < 10000) begin
            errors++;
            $display("[TB] FAIL rand_progress: accepted %0d ops within cycle budget, required 10000", accepted);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
            if (obsDrain && sb.size() != 0) begin
                expItem = sb.pop_front();
                checks++;
                if (obsResult !== expItem.result || obsRd !== expItem.rd || obsWen !== expItem.wen) begin
                    errors++;
                    $display("[TB] FAIL rand_tail: got %h rd%0d wen%b, required %h rd%0d wen%b",
                             obsResult, obsRd, obsWen, expItem.result, expItem.rd, expItem.wen);
                end
            end
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_drain: outstanding=%0d out_valid=%b, required 0 0", sb.size(), out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_a = '0;
        in_b = '0;
        in_rd = '0;
        in_wen = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_alu_sweep();
        test_x0_illegal();
        test_back_to_back();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
